axi_mat_loader: RTL and testbench
=================================

Name: axi_mat_loader

Overview:
- Memory-side counterpart of the tensorcore's AXI request struct (AXI_out_t / AXI_in_t).
- Accepts one load request: matrix select, base addresses, burst count/size, bit budget.
- Issues AXI4 read bursts, steers returned beats into the SRAM A, B or C write port (B/C double-buffered), then returns a single-cycle finish.
- Sits between the systolic controller (INIT_WAIT_A/B/C, WAIT_A/B states) and the AXI interconnect.
- D write-back is a separate block; sel=000 is rejected here.

Parameters:
- DATA_W, 32, AXI read data width in bits (32 or 64).
- SRAM_AW, 8, SRAM word-address width per bank.
- ADDR_W, 32, AXI address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  AXI_out_t  request struct; fields A/B/C_BASE, sel, recvbits, burst_num, burst_size, request_valid
- fin_o  out  AXI_in_t  finish pulse (.finish)
- err_o  out  1  qualifies fin_o: request rejected
- busy_o  out  1  high whenever not IDLE
- ar_valid  out  1  AXI read address valid
- ar_ready  in  1  AXI read address ready
- ar_addr  out  ADDR_W  burst start address
- ar_len  out  8  beats-1
- ar_size  out  3  log2(DATA_W/8)
- r_valid  in  1  read data valid
- r_ready  out  1  read data ready
- r_data  in  DATA_W  read data
- r_last  in  1  last beat of burst
- sram_we_a / sram_we_b / sram_we_c  out  1 each  write strobes
- sram_bank  out  1  bank of B/C double buffer being written
- sram_addr  out  SRAM_AW  word address
- sram_wdata  out  DATA_W  write data

Behaviour:
- Reset: all outputs 0; state IDLE; bank toggles for B and C cleared to 0.
- Reset mid-operation: abandon transfer, no fin_o, no further SRAM writes. Outstanding AXI beats are the interconnect's concern.
- Handshakes: AXI valid/ready; a transfer happens when both are high in the same cycle.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: on req_i.request_valid, latch the whole struct.
  - Reject if sel is not one of 100/010/001, burst_num==0, or burst_size==0: go to DONE with err set.
  - Otherwise go to ADDR with:
    - addr = A_BASE, B_BASE or C_BASE, per sel.
    - beat cnt = 0, burst cnt = 0, sram_addr = 0, bits_written = 0.
- ADDR: ar_valid=1, ar_len=burst_size-1, ar_size constant. Hold all AR signals stable until ar_ready; then go to DATA.
- DATA: r_ready=1. On each r_valid beat:
  - Write r_data to the selected SRAM, but only while bits_written < recvbits; then sram_addr+=1 and bits_written+=DATA_W.
  - A partial final beat is written whole.
  - Excess beats are accepted and dropped, with no strobe.
- On r_last:
  - burst cnt+=1; addr += burst_size*DATA_W/8.
  - Go to ADDR if burst cnt<burst_num, else DONE.
  - r_last arriving early or late is not checked; r_last alone ends the burst.
- One burst outstanding at a time. No AR is issued before the previous r_last.
- DONE (1 cycle): fin_o.finish=1; err_o=err. For successful B/C loads, toggle that matrix's bank. Then return to IDLE.
- sram_bank output:
  - Driven during DATA as the current bank of the selected matrix.
  - Always 0 for A, which is single-buffered.
- Latency:
  - First ar_valid: cycle after accept.
  - fin_o: cycle after the final r_last handshake.
  - Rejected request: fin_o 1 cycle after accept.
- Combinational SRAM strobe: sram_we_x = r_valid & r_ready & in-budget & sel match. Address and data are registered-free pass-through from counters / r_data.
- request_valid while busy (including DONE) is ignored, not queued.
- sram_addr wraps at 2^SRAM_AW silently. Sizing requests to fit is the requester's responsibility.
- bits_written is a saturating 32-bit counter.

Decomposition:
- Shared package (params):
  - Existing AXI_out_t and AXI_in_t.
  - New enum ld_state_t {LD_IDLE, LD_ADDR, LD_DATA, LD_DONE}.
  - localparams SEL_A=3'b100, SEL_B=3'b010, SEL_C=3'b001, SEL_D=3'b000.
- One natural sub-module: axi_burst_addr_gen.
  - Owns the address, burst and beat counters.
  - Exposes next-address and last-burst outputs.
- FSM and SRAM steering remain top-level.

Test Plan:
- Single-burst A load: sel=100, A_BASE=0x1000, burst_num=1, burst_size=16, recvbits=512, DATA_W=32, ready always high.
  - Exactly one AR with addr 0x1000, len 15.
  - 16 sram_we_a strobes, addresses 0..15.
  - fin_o one cycle after r_last; err_o=0.
- Multi-burst B with backpressure: burst_num=4, burst_size=8, B_BASE=0x2000, ar_ready delayed 3 cycles each burst.
  - AR addrs 0x2000, 0x2020, 0x2040, 0x2060, each held stable until ready.
  - 32 writes, sram_bank=0.
  - A second B request writes with sram_bank=1.
- Budget truncation: recvbits=200, burst_size=8.
  - Beats 0..6 written (224 bits ≥ 200 after the 7th).
  - Beat 7 accepted, r_ready=1, no strobe.
- Illegal request: sel=000 or burst_num=0.
  - No ar_valid.
  - fin_o and err_o high exactly 1 cycle after accept.
- Busy-drop and reset: a second request_valid during DATA is ignored (single fin_o).
  - rst asserted mid-DATA: next cycle all outputs 0, no fin_o, B/C banks back to 0.
- Gapped r_valid (valid every other cycle, C load): write count and addresses identical to the gap-free run; sram_we_c only on valid beats.

Source files
------------

// File: rtl/axi_mat_loader_pkg.sv
// Shared types for the tensorcore AXI matrix loader.
//   AXI_out_t   : load request issued by the systolic controller
//   AXI_in_t    : completion returned to the systolic controller
//   ld_state_t  : loader FSM states
//   SEL_*       : one-hot matrix select codes (SEL_D belongs to the write-back block)
package axi_mat_loader_pkg;

    localparam int BURST_NUM_W  = 8;   // bursts per request, 1..255
    localparam int BURST_SIZE_W = 9;   // beats per burst, 1..256

    typedef struct packed {
        logic [31:0]             A_BASE;
        logic [31:0]             B_BASE;
        logic [31:0]             C_BASE;
        logic [2:0]              sel;
        logic [31:0]             recvbits;
        logic [BURST_NUM_W-1:0]  burst_num;
        logic [BURST_SIZE_W-1:0] burst_size;
        logic                    request_valid;
    } AXI_out_t;

    typedef struct packed {
        logic finish;
    } AXI_in_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_ADDR,
        LD_DATA,
        LD_DONE
    } ld_state_t;

    localparam logic [2:0] SEL_A = 3'b100;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_C = 3'b001;
    localparam logic [2:0] SEL_D = 3'b000;

endpackage

// File: rtl/axi_mat_loader_addr_gen.sv
// Burst address generator for the matrix loader.
// Holds the start address of the burst to be issued next and counts completed
// bursts.
//   load       : capture base address, burst count and burst size (new request)
//   burst_done : r_last handshake; advance to the following burst
//   next_addr  : start address for the next AR
//   last_burst : the burst in flight is the final one of the request
module axi_burst_addr_gen
    import axi_mat_loader_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [BURST_NUM_W-1:0]  burst_num,
    input  logic [BURST_SIZE_W-1:0] burst_size,
    input  logic                    burst_done,
    output logic [ADDR_W-1:0]       next_addr,
    output logic                    last_burst
);

    localparam int BYTES_PER_BEAT = DATA_W / 8;

    logic [BURST_NUM_W-1:0]  burst_cnt;
    logic [BURST_NUM_W-1:0]  burst_num_q;
    logic [BURST_SIZE_W-1:0] burst_size_q;

    assign last_burst = (burst_cnt + 1'b1) == burst_num_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr    <= '0;
            burst_cnt    <= '0;
            burst_num_q  <= '0;
            burst_size_q <= '0;
        end else if (load) begin
            next_addr    <= base_addr;
            burst_cnt    <= '0;
            burst_num_q  <= burst_num;
            burst_size_q <= burst_size;
        end else if (burst_done) begin
            next_addr <= next_addr + ADDR_W'(burst_size_q) * ADDR_W'(BYTES_PER_BEAT);
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axi_mat_loader.sv
// AXI4 read-burst matrix loader for the tensorcore SRAMs.
// Accepts one load request, fetches it as burst_num bursts of burst_size beats,
// steers beats into SRAM A, B or C (B/C double-buffered) up to recvbits, then
// returns a one-cycle finish (err_o set when the request was rejected).
//   clk, rst          : clock, synchronous active-high reset
//   req_i / fin_o     : request struct in, finish struct out; err_o qualifies fin_o
//   busy_o            : loader not idle
//   ar_* / r_*        : AXI4 read address and read data channels
//   sram_*            : SRAM write port (per-matrix strobes, shared addr/data/bank)
module axi_mat_loader
    import axi_mat_loader_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 8,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  AXI_out_t           req_i,
    output AXI_in_t            fin_o,
    output logic               err_o,
    output logic               busy_o,
    output logic               ar_valid,
    input  logic               ar_ready,
    output logic [ADDR_W-1:0]  ar_addr,
    output logic [7:0]         ar_len,
    output logic [2:0]         ar_size,
    input  logic               r_valid,
    output logic               r_ready,
    input  logic [DATA_W-1:0]  r_data,
    input  logic               r_last,
    output logic               sram_we_a,
    output logic               sram_we_b,
    output logic               sram_we_c,
    output logic               sram_bank,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata
);

    localparam logic [2:0]  AR_SIZE   = 3'($clog2(DATA_W / 8));
    localparam logic [31:0] BEAT_BITS = 32'(DATA_W);

    ld_state_t   state;
    logic [2:0]  sel_q;
    logic [31:0] recvbits_q;
    logic [31:0] bits_written;
    logic        err_q;
    logic        bank_b;
    logic        bank_c;

    logic              req_legal;
    logic              gen_load;
    logic              beat_hs;
    logic              burst_done;
    logic              in_budget;
    logic              last_burst;
    logic [ADDR_W-1:0] base_sel;

    assign req_legal = (req_i.sel == SEL_A || req_i.sel == SEL_B || req_i.sel == SEL_C)
                    && (req_i.burst_num != '0) && (req_i.burst_size != '0);

    assign base_sel = (req_i.sel == SEL_A) ? ADDR_W'(req_i.A_BASE) :
                      (req_i.sel == SEL_B) ? ADDR_W'(req_i.B_BASE) :
                                             ADDR_W'(req_i.C_BASE);

    assign gen_load   = (state == LD_IDLE) && req_i.request_valid && req_legal;
    assign beat_hs    = r_valid && r_ready;
    assign burst_done = beat_hs && r_last;
    assign in_budget  = bits_written < recvbits_q;

    // Beats past the bit budget are still accepted but never strobe the SRAM.
    assign sram_we_a  = beat_hs && in_budget && (sel_q == SEL_A);
    assign sram_we_b  = beat_hs && in_budget && (sel_q == SEL_B);
    assign sram_we_c  = beat_hs && in_budget && (sel_q == SEL_C);
    // r_ready is high exactly while in DATA, so it doubles as the DATA qualifier.
    assign sram_bank  = r_ready && (((sel_q == SEL_B) && bank_b) || ((sel_q == SEL_C) && bank_c));
    assign sram_wdata = r_ready ? r_data : '0;
    assign busy_o     = (state != LD_IDLE);

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (gen_load),
        .base_addr  (base_sel),
        .burst_num  (req_i.burst_num),
        .burst_size (req_i.burst_size),
        .burst_done (burst_done),
        .next_addr  (ar_addr),
        .last_burst (last_burst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LD_IDLE;
            fin_o        <= '0;
            err_o        <= 1'b0;
            ar_valid     <= 1'b0;
            ar_len       <= '0;
            ar_size      <= '0;
            r_ready      <= 1'b0;
            sram_addr    <= '0;
            sel_q        <= '0;
            recvbits_q   <= '0;
            bits_written <= '0;
            err_q        <= 1'b0;
            bank_b       <= 1'b0;
            bank_c       <= 1'b0;
        end else begin
            ar_size      <= AR_SIZE;
            fin_o.finish <= 1'b0;
            err_o        <= 1'b0;

            case (state)
                LD_IDLE: begin
                    if (req_i.request_valid) begin
                        sel_q        <= req_i.sel;
                        recvbits_q   <= req_i.recvbits;
                        sram_addr    <= '0;
                        bits_written <= '0;
                        if (req_legal) begin
                            err_q    <= 1'b0;
                            ar_valid <= 1'b1;
                            ar_len   <= 8'(req_i.burst_size - 1'b1);
                            state    <= LD_ADDR;
                        end else begin
                            err_q        <= 1'b1;
                            fin_o.finish <= 1'b1;
                            err_o        <= 1'b1;
                            state        <= LD_DONE;
                        end
                    end
                end

                LD_ADDR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= LD_DATA;
                    end
                end

                LD_DATA: begin
                    if (r_valid) begin
                        if (in_budget) begin
                            sram_addr <= sram_addr + 1'b1;
                            bits_written <= (bits_written > (32'hFFFF_FFFF - BEAT_BITS))
                                          ? 32'hFFFF_FFFF : bits_written + BEAT_BITS;
                        end
                        // r_last alone closes the burst; beat counts are not checked.
                        if (r_last) begin
                            r_ready <= 1'b0;
                            if (last_burst) begin
                                fin_o.finish <= 1'b1;
                                state        <= LD_DONE;
                            end else begin
                                ar_valid <= 1'b1;
                                state    <= LD_ADDR;
                            end
                        end
                    end
                end

                LD_DONE: begin
                    if (!err_q && sel_q == SEL_B) bank_b <= ~bank_b;
                    if (!err_q && sel_q == SEL_C) bank_c <= ~bank_c;
                    state <= LD_IDLE;
                end

                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mat_loader.sv
// Directed bench for axi_mat_loader: a hand-written AXI slave drives the read
// channels, a negedge monitor logs SRAM writes and handshakes, and every
// expectation is a hand-computed constant or a simple counter.
module tb_axi_mat_loader;
    import axi_mat_loader_pkg::*;

    localparam int DATA_W  = 32;
    localparam int SRAM_AW = 8;
    localparam int ADDR_W  = 32;

    logic               clk;
    logic               rst;
    AXI_out_t           req;
    AXI_in_t            fin_o;
    logic               err_o, busy_o;
    logic               ar_valid, ar_ready;
    logic [ADDR_W-1:0]  ar_addr;
    logic [7:0]         ar_len;
    logic [2:0]         ar_size;
    logic               r_valid, r_ready, r_last;
    logic [DATA_W-1:0]  r_data;
    logic               sram_we_a, sram_we_b, sram_we_c, sram_bank;
    logic [SRAM_AW-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_wdata;

    axi_mat_loader #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_i(req), .fin_o(fin_o), .err_o(err_o), .busy_o(busy_o),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .r_last(r_last), .sram_we_a(sram_we_a), .sram_we_b(sram_we_b), .sram_we_c(sram_we_c),
        .sram_bank(sram_bank), .sram_addr(sram_addr), .sram_wdata(sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: only this process writes these; the stimulus works from snapshots.
    typedef struct {
        logic [2:0]  we;
        logic [7:0]  addr;
        logic        bank;
        logic [31:0] data;
    } wr_t;

    wr_t wlog[$];
    int  ar_hs = 0, beats_acc = 0, fin_cnt = 0, we_bad = 0;

    always @(negedge clk) begin
        if (ar_valid && ar_ready) ar_hs++;
        if (r_valid && r_ready) beats_acc++;
        if (fin_o.finish) fin_cnt++;
        if ((sram_we_a || sram_we_b || sram_we_c) && !r_valid) we_bad++;
        if ((int'(sram_we_a) + int'(sram_we_b) + int'(sram_we_c)) > 1) we_bad++;
        if (sram_we_a || sram_we_b || sram_we_c)
            wlog.push_back('{we: {sram_we_a, sram_we_b, sram_we_c}, addr: sram_addr,
                             bank: sram_bank, data: sram_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // One-cycle request pulse; returns in the cycle after the accepting edge.
    task automatic send_req(input logic [2:0] sel, input logic [7:0] bn,
                            input logic [8:0] bs, input logic [31:0] recv);
        req.sel           = sel;
        req.burst_num     = bn;
        req.burst_size    = bs;
        req.recvbits      = recv;
        req.request_valid = 1'b1;
        @(posedge clk); #1;
        req.request_valid = 1'b0;
    endtask

    // Wait (bounded) for ar_valid, stall `delay` cycles checking stability, then accept.
    task automatic do_ar(input int delay, output logic [31:0] addr, output logic [7:0] len,
                         output logic ok, output logic stable);
        int waited = 0;
        stable = 1'b1;
        while (!ar_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        ok   = ar_valid;
        addr = ar_addr;
        len  = ar_len;
        if (!ok) return;
        repeat (delay) begin
            @(posedge clk); #1;
            if (!ar_valid || ar_addr !== addr || ar_len !== len) stable = 1'b0;
        end
        ar_ready = 1'b1;
        @(posedge clk); #1;
        ar_ready = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit gap, input logic [31:0] seed,
                              input bit with_last);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                r_valid = 1'b0;
                r_last  = 1'b0;
                @(posedge clk); #1;
            end
            r_valid = 1'b1;
            r_data  = seed + 32'(i);
            r_last  = with_last && (i == n - 1);
            @(posedge clk); #1;
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_data  = '0;
    endtask

    task automatic check_writes(input string tag, input int base, input int n,
                                input logic [2:0] we_exp, input logic bank_exp,
                                input logic [31:0] seed);
        int bad = 0;
        check({tag, "_wr_count"}, 64'(wlog.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < wlog.size(); i++) begin
            wr_t w = wlog[base + i];
            if (w.we !== we_exp || w.addr !== 8'(i) || w.bank !== bank_exp ||
                w.data !== seed + 32'(i)) bad++;
        end
        check({tag, "_wr_content"}, 64'(bad), 64'd0);
    endtask

    logic [31:0] a_addr;
    logic [7:0]  a_len;
    logic        a_ok, a_stable;
    int          b_ar, b_w, b_fin, b_beats;

    task automatic snap();
        b_ar    = ar_hs;
        b_w     = wlog.size();
        b_fin   = fin_cnt;
        b_beats = beats_acc;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        req.A_BASE = 32'h0000_1000;
        req.B_BASE = 32'h0000_2000;
        req.C_BASE = 32'h0000_3000;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        r_last     = 1'b0;
        r_data     = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;

        // ---- reset state ----
        check("rst_ctrl", {fin_o.finish, err_o, busy_o, ar_valid, r_ready,
                           sram_we_a, sram_we_b, sram_we_c, sram_bank}, 0);
        check("rst_ar", {ar_addr, ar_len, ar_size}, 0);
        check("rst_sram", {sram_addr, sram_wdata}, 0);
        rst    = 1'b0;
        r_data = '0;
        @(posedge clk); #1;
        check("ar_size_const", ar_size, 3'd2);

        // ---- single-burst A load ----
        snap();
        send_req(SEL_A, 8'd1, 9'd16, 32'd512);
        check("a_ar_next_cycle", ar_valid, 1);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        check("a_ar_seen", a_ok, 1);
        check("a_ar_addr", a_addr, 32'h1000);
        check("a_ar_len", a_len, 8'd15);
        send_beats(16, 0, 32'hA000_0000, 1);
        check("a_fin_err", {fin_o.finish, err_o}, 2'b10);
        @(posedge clk); #1;
        check("a_fin_one_cycle", {fin_o.finish, busy_o}, 0);
        check("a_ar_count", 64'(ar_hs - b_ar), 1);
        check_writes("a", b_w, 16, 3'b100, 1'b0, 32'hA000_0000);

        // ---- multi-burst B with AR backpressure ----
        snap();
        send_req(SEL_B, 8'd4, 9'd8, 32'd1024);
        for (int k = 0; k < 4; k++) begin
            do_ar(3, a_addr, a_len, a_ok, a_stable);
            check("b_ar_seen", a_ok, 1);
            check("b_ar_addr", a_addr, 32'h2000 + 32'(k) * 32'h20);
            check("b_ar_len", a_len, 8'd7);
            check("b_ar_stable", a_stable, 1);
            send_beats(8, 0, 32'hB000_0000 + 32'(8 * k), 1);
        end
        check("b_fin_err", {fin_o.finish, err_o}, 2'b10);
        @(posedge clk); #1;
        check("b_ar_count", 64'(ar_hs - b_ar), 4);
        check_writes("b", b_w, 32, 3'b010, 1'b0, 32'hB000_0000);

        // second B load lands in the other bank
        snap();
        send_req(SEL_B, 8'd1, 9'd4, 32'd128);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        send_beats(4, 0, 32'hB100_0000, 1);
        check("b2_fin", fin_o.finish, 1);
        @(posedge clk); #1;
        check_writes("b2", b_w, 4, 3'b010, 1'b1, 32'hB100_0000);

        // ---- budget truncation: 200 bits -> 7 of 8 beats written ----
        snap();
        send_req(SEL_A, 8'd1, 9'd8, 32'd200);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        send_beats(8, 0, 32'hC0DE_0000, 1);
        check("trunc_fin", {fin_o.finish, err_o}, 2'b10);
        @(posedge clk); #1;
        check("trunc_beats_accepted", 64'(beats_acc - b_beats), 8);
        check_writes("trunc", b_w, 7, 3'b100, 1'b0, 32'hC0DE_0000);

        // ---- illegal requests ----
        snap();
        send_req(SEL_D, 8'd1, 9'd4, 32'd128);
        check("ill_sel_fin_err", {fin_o.finish, err_o, ar_valid}, 3'b110);
        @(posedge clk); #1;
        check("ill_sel_after", {fin_o.finish, err_o, busy_o}, 0);
        send_req(SEL_A, 8'd0, 9'd4, 32'd128);
        check("ill_bn0_fin_err", {fin_o.finish, err_o, ar_valid}, 3'b110);
        @(posedge clk); #1;
        send_req(SEL_C, 8'd1, 9'd0, 32'd128);
        check("ill_bs0_fin_err", {fin_o.finish, err_o, ar_valid}, 3'b110);
        repeat (3) @(posedge clk);
        #1;
        check("ill_no_ar", 64'(ar_hs - b_ar), 0);
        check("ill_fin_count", 64'(fin_cnt - b_fin), 3);

        // ---- gapped r_valid, C load ----
        snap();
        send_req(SEL_C, 8'd2, 9'd4, 32'd256);
        for (int k = 0; k < 2; k++) begin
            do_ar(0, a_addr, a_len, a_ok, a_stable);
            check("c_ar_addr", a_addr, 32'h3000 + 32'(k) * 32'h10);
            send_beats(4, 1, 32'hCC00_0000 + 32'(4 * k), 1);
        end
        check("c_fin", {fin_o.finish, err_o}, 2'b10);
        @(posedge clk); #1;
        check_writes("c_gap", b_w, 8, 3'b001, 1'b0, 32'hCC00_0000);

        // ---- request while busy is dropped (B bank is 0 again) ----
        snap();
        send_req(SEL_B, 8'd1, 9'd4, 32'd128);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        req.sel           = SEL_A;
        req.request_valid = 1'b1;
        @(posedge clk); #1;
        req.request_valid = 1'b0;
        send_beats(4, 0, 32'hB200_0000, 1);
        repeat (4) @(posedge clk);
        #1;
        check("busy_fin_count", 64'(fin_cnt - b_fin), 1);
        check("busy_ar_count", 64'(ar_hs - b_ar), 1);
        check_writes("busy", b_w, 4, 3'b010, 1'b0, 32'hB200_0000);

        // ---- reset mid-DATA on a C load (C bank is 1, B bank is 1) ----
        snap();
        send_req(SEL_C, 8'd1, 9'd8, 32'd256);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        send_beats(3, 0, 32'hCD00_0000, 0);
        check_writes("pre_rst", b_w, 3, 3'b001, 1'b1, 32'hCD00_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        r_valid = 1'b1;
        r_data  = 32'h1234_5678;
        #1;
        check("midrst_ctrl", {fin_o.finish, err_o, busy_o, ar_valid, r_ready,
                              sram_we_a, sram_we_b, sram_we_c, sram_bank}, 0);
        check("midrst_ar", {ar_addr, ar_len, ar_size}, 0);
        check("midrst_sram", {sram_addr, sram_wdata}, 0);
        r_valid = 1'b0;
        r_data  = '0;
        rst     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_fin", 64'(fin_cnt - b_fin), 0);
        check("midrst_no_writes", 64'(wlog.size() - b_w), 3);

        // banks cleared by reset
        snap();
        send_req(SEL_B, 8'd1, 9'd2, 32'd64);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        send_beats(2, 0, 32'hBB00_0000, 1);
        @(posedge clk); #1;
        check_writes("rst_bank_b", b_w, 2, 3'b010, 1'b0, 32'hBB00_0000);
        snap();
        send_req(SEL_C, 8'd1, 9'd2, 32'd64);
        do_ar(0, a_addr, a_len, a_ok, a_stable);
        send_beats(2, 0, 32'hCE00_0000, 1);
        @(posedge clk); #1;
        check_writes("rst_bank_c", b_w, 2, 3'b001, 1'b0, 32'hCE00_0000);

        check("no_stray_strobes", 64'(we_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
